// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline-stage register with synchronous
// flush and a saturating count of entries killed by flush.
// Build option: define PIPE_STAGE_SKID_EN to add a skid entry. The skid entry
// makes in_ready come straight from a register, which breaks the combinational
// out_ready -> in_ready path.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Main entry
  logic              mv_q, mv_d;
  logic [DATA_W-1:0] md_q, md_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic              sv_w;
  logic              in_fire;
  logic              out_fire;
  logic [1:0]        held_cnt;
  logic [SUM_W-1:0]  drop_sum;

`ifdef PIPE_STAGE_SKID_EN
  // Skid entry; it only ever fills while the main entry is stalled
  logic              sv_q, sv_d;
  logic [DATA_W-1:0] sd_q, sd_d;

  assign sv_w     = sv_q;
  assign in_ready = ~sv_q;
`else
  assign sv_w     = 1'b0;
  assign in_ready = ~mv_q | out_ready;
`endif

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = mv_q & out_ready;
  assign held_cnt   = {1'b0, mv_q} + {1'b0, sv_w};
  assign drop_sum   = {1'b0, drop_q} + SUM_W'(held_cnt);

  assign out_valid  = mv_q;
  assign out_data   = md_q;
  assign occupancy  = held_cnt;
  assign drop_count = drop_q;

  // Next-state: flush, then refill M (skid first, FIFO order), then capture into S
  always_comb begin
    mv_d   = mv_q;
    md_d   = md_q;
    drop_d = drop_q;
`ifdef PIPE_STAGE_SKID_EN
    sv_d   = sv_q;
    sd_d   = sd_q;
`endif
    if (flush) begin
      mv_d   = 1'b0;
      md_d   = '0;
`ifdef PIPE_STAGE_SKID_EN
      sv_d   = 1'b0;
      sd_d   = '0;
`endif
      drop_d = drop_sum[CNT_W] ? CNT_MAX : drop_sum[CNT_W-1:0];
    end else if (out_fire || !mv_q) begin
`ifdef PIPE_STAGE_SKID_EN
      if (sv_q) begin
        mv_d = 1'b1;
        md_d = sd_q;
        sv_d = 1'b0;
      end else
`endif
      if (in_fire) begin
        mv_d = 1'b1;
        md_d = in_data;
      end else begin
        mv_d = 1'b0;
      end
    end
`ifdef PIPE_STAGE_SKID_EN
    else if (in_fire) begin
      sv_d = 1'b1;
      sd_d = in_data;
    end
`endif
  end

  // State registers; reset discards entries without counting them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mv_q   <= 1'b0;
      md_q   <= '0;
      drop_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      sv_q   <= 1'b0;
      sd_q   <= '0;
`endif
    end else begin
      mv_q   <= mv_d;
      md_q   <= md_d;
      drop_q <= drop_d;
`ifdef PIPE_STAGE_SKID_EN
      sv_q   <= sv_d;
      sd_q   <= sd_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus randomized traffic checked
// against a FIFO-queue reference model. Builds with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          flush, in_valid, out_ready, in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] drop_count;

  logic          s_flush, s_in_valid, s_out_ready, s_in_ready, s_out_valid;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [1:0]    s_occupancy;
  logic [1:0]    s_drop_count;

  int checks = 0;
  int errors = 0;

  // Reference model: entries held, in arrival order, plus drop total
  logic [DW-1:0] mq[$];
  int unsigned   m_drops = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .drop_count(drop_count)
  );

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .drop_count(s_drop_count)
  );

  function automatic logic model_in_ready();
    if (CAP == 2) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    logic inf, outf;
    int unsigned n;
    inf  = in_valid && model_in_ready();
    outf = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (flush) begin
      n = mq.size();
      m_drops = (m_drops + n > 65535) ? 65535 : m_drops + n;
      mq.delete();
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(in_data);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    checks++; if (drop_count !== '0) begin errors++; $display("FAIL reset_drop_count got %0d exp 0", drop_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 6; i++) begin
      drive(i <= 5, DW'(i), 1'b1, 1'b0);
      if (i > 1) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b exp 1", i, out_valid); end
        checks++; if (out_data !== DW'(i - 1)) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, out_data, DW'(i - 1)); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d exp 1", i, occupancy); end
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b exp 1", i, in_ready); end
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain_occ got %0d exp 0", occupancy); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] pending[$];
    logic [DW-1:0] got[$];
    logic acc;
    pending = '{DW'(32'hA), DW'(32'hB), DW'(32'hC)};
    for (int c = 0; c < 10; c++) begin
      drive(pending.size() > 0, (pending.size() > 0) ? pending[0] : '0, c >= 3, 1'b0);
      if (c == 2) begin
        checks++; if (occupancy !== 2'(CAP)) begin errors++; $display("FAIL bp_full_occ got %0d exp %0d", occupancy, CAP); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %0b exp 0", in_ready); end
      end
      checks++; if (in_ready !== model_in_ready()) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b exp %0b", c, in_ready, model_in_ready()); end
      if (mq.size() > 0) begin
        checks++; if (out_data !== mq[0]) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", c, out_data, mq[0]); end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      acc = in_valid && model_in_ready();
      tick();
      if (acc) void'(pending.pop_front());
    end
    checks++;
    if (got.size() != 3 || got[0] !== DW'(32'hA) || got[1] !== DW'(32'hB) || got[2] !== DW'(32'hC)) begin
      errors++;
      $display("FAIL bp_order got %0d items first %h exp A,B,C", got.size(), (got.size() > 0) ? got[0] : '0);
    end
  endtask

  task automatic test_flush();
    int unsigned d0;
    drive(1'b1, DW'(32'h11), 1'b0, 1'b0); tick();
    drive(1'b1, DW'(32'h22), 1'b0, 1'b0); tick();
    drive(1'b1, DW'(32'hD), 1'b0, 1'b1);
    d0 = m_drops;
    checks++; if (occupancy !== 2'(CAP)) begin errors++; $display("FAIL flush_pre_occ got %0d exp %0d", occupancy, CAP); end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %0b exp 0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b exp 1", in_ready); end
    checks++; if (drop_count !== CW'(d0 + CAP)) begin errors++; $display("FAIL flush_drops got %0d exp %0d", drop_count, d0 + CAP); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d] got valid data %h", i, out_data); end
      tick();
    end
  endtask

  task automatic test_flush_out_fire();
    int unsigned d0;
    drive(1'b1, DW'(32'h55), 1'b0, 1'b0); tick();
    d0 = m_drops;
    drive(1'b0, '0, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== DW'(32'h55)) begin errors++; $display("FAIL flushfire_fire got v=%0b d=%h exp v=1 d=55", out_valid, out_data); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flushfire_valid got %0b exp 0", out_valid); end
    checks++; if (drop_count !== CW'(d0 + 1)) begin errors++; $display("FAIL flushfire_drops got %0d exp %0d", drop_count, d0 + 1); end
    tick();
  endtask

  task automatic test_saturation();
    int unsigned exp_d;
    exp_d = 0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk); s_in_valid = 1'b1; s_in_data = DW'(r); s_out_ready = 1'b0; s_flush = 1'b0;
      @(negedge clk); s_in_data = DW'(r + 100);
      @(negedge clk); s_in_valid = 1'b0; s_flush = 1'b1; #1;
      checks++; if (s_occupancy !== 2'(CAP)) begin errors++; $display("FAIL sat_occ[%0d] got %0d exp %0d", r, s_occupancy, CAP); end
      @(negedge clk); s_flush = 1'b0; #1;
      exp_d = (exp_d + CAP > 3) ? 3 : exp_d + CAP;
      checks++; if (s_drop_count !== 2'(exp_d)) begin errors++; $display("FAIL sat_drops[%0d] got %0d exp %0d", r, s_drop_count, exp_d); end
      checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL sat_valid[%0d] got %0b exp 0", r, s_out_valid); end
    end
  endtask

  task automatic test_random();
    logic v, o, f;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      o = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 19) == 0);
      drive(v, DW'($urandom), o, f);
      checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %0b exp %0b", i, out_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++; if (out_data !== mq[0]) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", i, out_data, mq[0]); end
      end
      checks++; if (occupancy !== 2'(mq.size())) begin errors++; $display("FAIL rnd_occ[%0d] got %0d exp %0d", i, occupancy, mq.size()); end
      checks++; if (in_ready !== model_in_ready()) begin errors++; $display("FAIL rnd_in_ready[%0d] got %0b exp %0b", i, in_ready, model_in_ready()); end
      checks++; if (drop_count !== CW'(m_drops)) begin errors++; $display("FAIL rnd_drops[%0d] got %0d exp %0d", i, drop_count, m_drops); end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, DW'(32'h66), 1'b0, 1'b0); tick();
    drive(1'b1, DW'(32'h77), 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'(CAP)) begin errors++; $display("FAIL rstmid_pre_occ got %0d exp %0d", occupancy, CAP); end
    #2 reset = 1'b1;
    #1;
    mq.delete();
    m_drops = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rstmid_data got %h exp 0", out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rstmid_occ got %0d exp 0", occupancy); end
    checks++; if (drop_count !== '0) begin errors++; $display("FAIL rstmid_drops got %0d exp 0", drop_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %0b exp 1", in_ready); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
    test_reset();
    test_saturation();
    test_streaming();
    test_backpressure();
    test_flush();
    test_flush_out_fire();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register that replaces the fixed-field, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an opaque packed payload of configurable width and uses a valid/ready handshake, so a downstream stage can stall an upstream stage without external enable logic. It supports synchronous flush and counts the number of valid entries discarded by flushes. An optional skid entry breaks the combinational ready path.

## Interface
- DATA_W, 160: payload width in bits (the packed stage bundle: PC+4, control, operands, immediate, CSR data, ALU result).
- CNT_W, 16: width of the drop counter.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- flush  in  1  synchronous kill of all held entries; highest priority after reset.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  DATA_W  payload from the main register.
- occupancy  out  2  number of valid entries held (0..2).
- drop_count  out  CNT_W  saturating count of valid entries killed by flush.

## Operation
- Storage consists of a main entry M (mv, md) and a skid entry S (sv, sd). S exists only with PIPE_STAGE_SKID_EN.
- Handshake events: in_fire = in_valid & in_ready; out_fire = mv & out_ready.
- Output mapping: out_valid = mv, out_data = md, occupancy = mv + sv.
- Flush (synchronous):
  - mv, sv <= 0 and md, sd <= 0.
  - drop_count <= sat(drop_count + mv + sv).
  - A simultaneous in_fire is discarded and is not counted.
  - out_fire in the flush cycle still completes; the entry consumed downstream is included in the drop count.
- Normal cycle, skid mode:
  - in_ready = ~sv, driven from a register only.
  - If out_fire or !mv, M refills in this priority order: from S if sv (then sv <= 0); else from in_data if in_fire; else mv <= 0.
  - If M holds (mv & !out_ready) and in_fire, S <= in_data and sv <= 1.
  - Ordering is strictly FIFO: S is never overtaken by in_data.
- Data registers load only on a valid capture. When mv drops, md retains its last value. Downstream must qualify out_data with out_valid.
- drop_count saturates at all-ones and never wraps. It is cleared only by reset.

## Timing
- Reset values: mv = sv = 0, md = sd = 0, out_valid = 0, out_data = 0, occupancy = 0, drop_count = 0, in_ready = 1.
- Latency: data accepted on edge N appears on out_data after edge N, so it is visible in cycle N+1.
- Throughput: 1 entry/cycle with out_ready held high, in both modes.
- Skid mode backpressure:
  - in_ready deasserts the cycle after S fills.
  - At most one further entry is accepted after out_ready falls.
- Flush effect: out_valid = 0 and in_ready = 1 in the cycle after the flush edge.
- Reset mid-transfer: entries are lost immediately and asynchronously, and drop_count is not incremented.
- Simultaneous out_fire and in_fire with S empty: M takes in_data, occupancy unchanged.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - Two entries (M + S).
  - in_ready is registered (= ~sv).
  - occupancy ranges 0..2.
- PIPE_STAGE_SKID_EN undefined:
  - Single entry M; S logic is absent and sv is constant 0.
  - in_ready = ~mv | out_ready, combinational from out_ready.
  - occupancy ranges 0..1.
  - All other behaviour is identical, including flush, drop counting and latency.

## Test plan
- Reset: assert reset mid-stream with mv = sv = 1 -> all outputs 0 immediately, in_ready = 1, drop_count = 0.
- Streaming: out_ready = 1, in_data = 0x1..0x5 on consecutive cycles -> out_data = 0x1..0x5 one cycle later each, occupancy constant 1, no bubbles.
- Backpressure (skid): out_ready = 0, send 0xA then 0xB -> occupancy = 2, in_ready = 0, in_valid with 0xC is held off. Raise out_ready -> outputs 0xA, 0xB, 0xC in order with no loss or duplication. Non-skid build: 0xB is held off instead.
- Flush: with occupancy = 2, pulse flush together with in_valid = 1 (data 0xD) -> next cycle out_valid = 0, occupancy = 0, drop_count += 2, and 0xD never appears at the output.
- Saturation: CNT_W = 2, three flushes each dropping 2 entries -> drop_count reads 2, then 3, then stays 3.
- Flush with out_fire: mv = 1, out_ready = 1, flush = 1 -> downstream sees one out_fire, drop_count += 1, out_valid = 0 next cycle.
